pcie_hcmd_tx_arb: RTL

Arbiter that sits directly downstream of the host-command block in the PCIe user-clock domain. It merges that block's two TX request channels into one TLP request stream for the TX engine:
- SQ-entry fetch requests: memory reads.
- CQ-entry writes: memory writes carrying payload.

It also streams the CQ write payload from the host-command CQ FIFO through a 2-entry skid buffer. A request is acknowledged to its source only once the TX engine has accepted it.

---
 rtl/pcie_hcmd_tx_pkg.sv | 29 ++
 rtl/pcie_hcmd_tx_skid.sv | 53 +++++
 rtl/pcie_hcmd_tx_arb.sv | 119 +++++++++++
 3 files changed

// File: rtl/pcie_hcmd_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pcie_hcmd_tx_pkg : shared types and helpers for the host-command TX  |
// | request arbiter.                                                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pcie_hcmd_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DATA = 2'd3
  } tx_state_t;

  localparam logic C_REQ_MRD = 1'b0;
  localparam logic C_REQ_MWR = 1'b1;
  localparam int   C_BEAT_DW = 16;

  // A zero length field stands for the 1024 DW maximum, i.e. 64 beats.
  function automatic logic [7:0] beat_count(input logic [10:0] len);
    logic [11:0] w_sum;
    w_sum = {1'b0, len} + 12'(C_BEAT_DW - 1);
    if (len == 11'd0) return 8'd64;
    return w_sum[11:4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_hcmd_tx_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pcie_hcmd_tx_skid : 2-entry valid/ready skid buffer for CQ payload.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pcie_hcmd_tx_skid #(
  parameter int C_WIDTH = 513
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic [C_WIDTH-1:0] i_data,
  output logic               o_ready,
  output logic               o_valid,
  output logic [C_WIDTH-1:0] o_data,
  input  logic               i_ready
);

  logic [C_WIDTH-1:0] r_mem [0:1];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic               w_push;
  logic               w_pop;

  // Readiness depends only on the registered fill level, never on i_ready.
  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pcie_hcmd_tx_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pcie_hcmd_tx_arb : round-robin merge of SQ fetch reads and CQ writes |
// | into one TLP request stream, with CQ payload through a skid buffer.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pcie_hcmd_tx_arb
  import pcie_hcmd_tx_pkg::*;
#(
  parameter int C_PCIE_DATA_WIDTH = 512,
  parameter int C_PCIE_ADDR_WIDTH = 48
) (
  input  logic                           pcie_user_clk,
  input  logic                           pcie_user_rst,
  input  logic                           tx_mrd_req,
  input  logic [7:0]                     tx_mrd_tag,
  input  logic [10:0]                    tx_mrd_len,
  input  logic [C_PCIE_ADDR_WIDTH-1:2]   tx_mrd_addr,
  output logic                           tx_mrd_req_ack,
  input  logic                           tx_cq_mwr_req,
  input  logic [7:0]                     tx_cq_mwr_tag,
  input  logic [10:0]                    tx_cq_mwr_len,
  input  logic [C_PCIE_ADDR_WIDTH-1:2]   tx_cq_mwr_addr,
  output logic                           tx_cq_mwr_req_ack,
  output logic                           tx_cq_mwr_rd_en,
  input  logic [C_PCIE_DATA_WIDTH-1:0]   tx_cq_mwr_rd_data,
  output logic                           tx_cq_mwr_data_last,
  output logic                           tx_req_valid,
  input  logic                           tx_req_ready,
  output logic                           tx_req_type,
  output logic [7:0]                     tx_req_tag,
  output logic [10:0]                    tx_req_len,
  output logic [C_PCIE_ADDR_WIDTH-1:2]   tx_req_addr,
  output logic                           tx_wr_data_valid,
  input  logic                           tx_wr_data_ready,
  output logic [C_PCIE_DATA_WIDTH-1:0]   tx_wr_data,
  output logic                           tx_wr_data_last
);

  tx_state_t r_state;
  logic      r_rr_last;
  logic [7:0] r_beat_cnt;
  logic      w_grant_mwr;
  logic      w_skid_ready;

  // On a tie, the source that was not granted last time wins.
  assign w_grant_mwr = tx_cq_mwr_req & (~tx_mrd_req | (r_rr_last == C_REQ_MRD));

  assign tx_cq_mwr_rd_en     = (r_beat_cnt != 8'd0) & w_skid_ready;
  assign tx_cq_mwr_data_last = tx_cq_mwr_rd_en & (r_beat_cnt == 8'd1);

  always_ff @(posedge pcie_user_clk) begin
    if (pcie_user_rst) begin
      r_state           <= S_IDLE;
      r_rr_last         <= C_REQ_MWR;
      r_beat_cnt        <= 8'd0;
      tx_req_valid      <= 1'b0;
      tx_req_type       <= C_REQ_MRD;
      tx_req_tag        <= '0;
      tx_req_len        <= '0;
      tx_req_addr       <= '0;
      tx_mrd_req_ack    <= 1'b0;
      tx_cq_mwr_req_ack <= 1'b0;
    end else begin
      tx_mrd_req_ack    <= 1'b0;
      tx_cq_mwr_req_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tx_mrd_req | tx_cq_mwr_req) begin
            tx_req_valid <= 1'b1;
            tx_req_type  <= w_grant_mwr;
            tx_req_tag   <= w_grant_mwr ? tx_cq_mwr_tag  : tx_mrd_tag;
            tx_req_len   <= w_grant_mwr ? tx_cq_mwr_len  : tx_mrd_len;
            tx_req_addr  <= w_grant_mwr ? tx_cq_mwr_addr : tx_mrd_addr;
            r_rr_last    <= w_grant_mwr;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (tx_req_ready) begin
            tx_req_valid <= 1'b0;
            if (tx_req_type == C_REQ_MRD) begin
              tx_mrd_req_ack <= 1'b1;
              r_state        <= S_HOLD;
            end else begin
              tx_cq_mwr_req_ack <= 1'b1;
              r_beat_cnt        <= beat_count(tx_req_len);
              r_state           <= S_DATA;
            end
          end
        end
        // Gives the acknowledged source a cycle to drop its request line.
        S_HOLD: r_state <= S_IDLE;
        S_DATA: begin
          if (tx_cq_mwr_rd_en) begin
            r_beat_cnt <= r_beat_cnt - 8'd1;
            if (r_beat_cnt == 8'd1) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  pcie_hcmd_tx_skid #(
    .C_WIDTH (C_PCIE_DATA_WIDTH + 1)
  ) u_skid (
    .clk     (pcie_user_clk),
    .rst     (pcie_user_rst),
    .i_valid (tx_cq_mwr_rd_en),
    .i_data  ({tx_cq_mwr_data_last, tx_cq_mwr_rd_data}),
    .o_ready (w_skid_ready),
    .o_valid (tx_wr_data_valid),
    .o_data  ({tx_wr_data_last, tx_wr_data}),
    .i_ready (tx_wr_data_ready)
  );

endmodule
`default_nettype wire
